// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the three-master memory-port arbiter:
//   - arb_state_e : FSM state encoding (IDLE, BUSY, DRAIN)
//   - M1/M2/M3    : master bit indices in req/done/gnt
//   - ACC_*       : owner codes driven on accmodule
//   - pick()      : fixed-priority M1, round-robin M2/M3 selection
//   - acc_code()  : one-hot grant to owner code
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int M1 = 0;
    localparam int M2 = 1;
    localparam int M3 = 2;

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_M1   = 2'd1;
    localparam logic [1:0] ACC_M2   = 2'd2;
    localparam logic [1:0] ACC_M3   = 2'd3;

    // rr_m3 = 1 means M3 wins the next M2/M3 contention.
    function automatic logic [2:0] pick(input logic [2:0] r, input logic rr_m3);
        logic [2:0] g;
        g = 3'b000;
        if (r[M1]) begin
            g = 3'b001;
        end else if (r[M2] && r[M3]) begin
            g = rr_m3 ? 3'b100 : 3'b010;
        end else if (r[M2]) begin
            g = 3'b010;
        end else if (r[M3]) begin
            g = 3'b100;
        end else begin
            g = 3'b000;
        end
        return g;
    endfunction

    function automatic logic [1:0] acc_code(input logic [2:0] g);
        logic [1:0] c;
        case (g)
            3'b001:  c = ACC_M1;
            3'b010:  c = ACC_M2;
            3'b100:  c = ACC_M3;
            default: c = ACC_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_arb_sat_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_sat_cnt
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Ports:
//   clk   in  1      clock
//   reset in  1      asynchronous active-high clear
//   inc   in  1      increment request
//   clear in  1      synchronous clear
//   q     out CNT_W  count
// -----------------------------------------------------------------------------
module mem_arb_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Count register with saturation at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= {CNT_W{1'b0}};
        end else if (clear) begin
            q <= {CNT_W{1'b0}};
        end else if (inc && (q != CNT_MAX)) begin
            q <= q + CNT_ONE;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/mem_share_arbiter.sv
// -----------------------------------------------------------------------------
// mem_share_arbiter
// Shares one memory port between M1 (urgent, preempting after MIN_HOLD cycles
// of an M2/M3 tenure) and M2/M3 (round-robin). All outputs are registered.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (MAX_HOLD tenure timeout with
// one-shot masking of the timed-out master and the nb_timeouts counter).
// Ports:
//   clk           in  1      clock
//   reset         in  1      asynchronous active-high reset
//   req           in  3      level requests, bit0=M1 bit1=M2 bit2=M3
//   done          in  3      end-of-access, only the owner's bit matters
//   gnt           out 3      one-hot grant (zero when no owner)
//   accmodule     out 2      owner code 0 none / 1 M1 / 2 M2 / 3 M3
//   arb_state     out 2      0 IDLE / 1 BUSY / 2 DRAIN
//   nb_interrupts out CNT_W  saturating preemption count
//   nb_timeouts   out CNT_W  saturating timeout count (0 without feature)
// -----------------------------------------------------------------------------
module mem_share_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MIN_HOLD = 2,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [2:0]       done,
    output logic [2:0]       gnt,
    output logic [1:0]       accmodule,
    output logic [1:0]       arb_state,
    output logic [CNT_W-1:0] nb_interrupts,
    output logic [CNT_W-1:0] nb_timeouts
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] MIN_HOLD_V = HOLD_W'(MIN_HOLD);
`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] MAX_HOLD_V = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT = MAX_HOLD_V;
`else
    localparam logic [HOLD_W-1:0] HOLD_SAT = MIN_HOLD_V;
`endif

    arb_state_e        state_r, state_s;
    logic [2:0]        gnt_r, gnt_s;
    logic [1:0]        acc_r;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic              rr_r, rr_s;
    logic [2:0]        avail_s;
    logic [2:0]        pick_avail_s;
    logic [2:0]        pick_rel_s;
    logic              release_s;
    logic              inc_int_s;
    logic              inc_to_s;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [2:0]        mask_r, mask_s;
`endif

`ifdef MEM_ARB_TIMEOUT_EN
    assign avail_s = req & ~mask_r;
`else
    assign avail_s = req;
`endif
    // On release the owner's own bit is excluded so a lingering req cannot re-win.
    assign pick_avail_s = pick(avail_s, rr_r);
    assign pick_rel_s   = pick(req & ~gnt_r, rr_r);
    assign release_s    = (|(done & gnt_r)) || !(|(req & gnt_r));

    // Next-state, next-grant and counter-increment decode.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        hold_s    = hold_r;
        inc_int_s = 1'b0;
        inc_to_s  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        mask_s    = mask_r;
`endif
        case (state_r)
            IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                mask_s = 3'b000;
`endif
                if (pick_avail_s != 3'b000) begin
                    state_s = BUSY;
                    gnt_s   = pick_avail_s;
                    hold_s  = HOLD_ONE;
                end else begin
                    state_s = IDLE;
                    gnt_s   = 3'b000;
                    hold_s  = {HOLD_W{1'b0}};
                end
            end
            BUSY: begin
                if (release_s) begin
                    if (pick_rel_s != 3'b000) begin
                        state_s = BUSY;
                        gnt_s   = pick_rel_s;
                        hold_s  = HOLD_ONE;
                    end else begin
                        state_s = IDLE;
                        gnt_s   = 3'b000;
                        hold_s  = {HOLD_W{1'b0}};
                    end
                end else if (!gnt_r[M1] && req[M1] && (hold_r >= MIN_HOLD_V)) begin
                    state_s   = DRAIN;
                    gnt_s     = 3'b000;
                    hold_s    = {HOLD_W{1'b0}};
                    inc_int_s = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (hold_r == MAX_HOLD_V) begin
                    state_s  = DRAIN;
                    gnt_s    = 3'b000;
                    hold_s   = {HOLD_W{1'b0}};
                    mask_s   = gnt_r;
                    inc_to_s = 1'b1;
`endif
                end else if (hold_r < HOLD_SAT) begin
                    hold_s = hold_r + HOLD_ONE;
                end else begin
                    hold_s = hold_r;
                end
            end
            DRAIN: begin
`ifdef MEM_ARB_TIMEOUT_EN
                mask_s = 3'b000;
`endif
                if (pick_avail_s != 3'b000) begin
                    state_s = BUSY;
                    gnt_s   = pick_avail_s;
                    hold_s  = HOLD_ONE;
                end else begin
                    state_s = IDLE;
                    gnt_s   = 3'b000;
                    hold_s  = {HOLD_W{1'b0}};
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = 3'b000;
                hold_s  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Granting M2 hands the next contention to M3 and vice versa; otherwise hold.
    always_comb begin
        if (gnt_s[M2]) begin
            rr_s = 1'b1;
        end else if (gnt_s[M3]) begin
            rr_s = 1'b0;
        end else begin
            rr_s = rr_r;
        end
    end

    // Arbiter state registers; accmodule is registered from the same next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            gnt_r   <= 3'b000;
            acc_r   <= ACC_NONE;
            hold_r  <= {HOLD_W{1'b0}};
            rr_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            acc_r   <= acc_code(gnt_s);
            hold_r  <= hold_s;
            rr_r    <= rr_s;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Timed-out master mask, live only across the DRAIN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= 3'b000;
        end else begin
            mask_r <= mask_s;
        end
    end
`endif

    mem_arb_sat_cnt #(.CNT_W(CNT_W)) u_int_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_int_s),
        .clear (1'b0),
        .q     (nb_interrupts)
    );

    mem_arb_sat_cnt #(.CNT_W(CNT_W)) u_to_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_to_s),
        .clear (1'b0),
        .q     (nb_timeouts)
    );

    assign gnt       = gnt_r;
    assign accmodule = acc_r;
    assign arb_state = state_r;

endmodule

// File: tb/tb_mem_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_share_arbiter
// Directed bench for mem_share_arbiter. Each step queues the expected
// registered outputs before the clock edge and compares them #1 after it.
// CNT_W is 2 so counter saturation is reached with a few preemptions.
// Honours MEM_ARB_TIMEOUT_EN for the timeout scenario.
// -----------------------------------------------------------------------------
module tb_mem_share_arbiter;
    import mem_arb_pkg::*;

    localparam int CW = 2;

    logic          clk;
    logic          reset;
    logic [2:0]    req;
    logic [2:0]    done;
    logic [2:0]    gnt;
    logic [1:0]    accmodule;
    logic [1:0]    arb_state;
    logic [CW-1:0] nb_interrupts;
    logic [CW-1:0] nb_timeouts;

    typedef struct {
        string      tag;
        logic [2:0] g;
        logic [1:0] acc;
        logic [1:0] st;
        logic [1:0] ni;
        logic [1:0] nt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [1:0] ni_exp;

    mem_share_arbiter #(.MIN_HOLD(2), .MAX_HOLD(8), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .done          (done),
        .gnt           (gnt),
        .accmodule     (accmodule),
        .arb_state     (arb_state),
        .nb_interrupts (nb_interrupts),
        .nb_timeouts   (nb_timeouts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] code_of(input logic [2:0] g);
        if (g == 3'b001) return 2'd1;
        else if (g == 3'b010) return 2'd2;
        else if (g == 3'b100) return 2'd3;
        else return 2'd0;
    endfunction

    task automatic check(input string tag, input string fld, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, act, exp);
        end
    endtask

    // Queue the expectation, advance one clock, then pop and compare.
    task automatic step(input string tag, input logic [2:0] g, input logic [1:0] st,
                        input logic [1:0] ni, input logic [1:0] nt);
        exp_t e;
        e.tag = tag; e.g = g; e.acc = code_of(g); e.st = st; e.ni = ni; e.nt = nt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.tag, "gnt", {5'd0, gnt}, {5'd0, e.g});
        check(e.tag, "acc", {6'd0, accmodule}, {6'd0, e.acc});
        check(e.tag, "state", {6'd0, arb_state}, {6'd0, e.st});
        check(e.tag, "nb_int", {6'd0, nb_interrupts}, {6'd0, e.ni});
        check(e.tag, "nb_to", {6'd0, nb_timeouts}, {6'd0, e.nt});
    endtask

    // Asynchronous reset: grant must drop before any clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check(tag, "gnt", {5'd0, gnt}, 8'd0);
        check(tag, "state", {6'd0, arb_state}, 8'd0);
        check(tag, "acc", {6'd0, accmodule}, 8'd0);
        req  = 3'b000;
        done = 3'b000;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 3'b000;
        done  = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset", "gnt", {5'd0, gnt}, 8'd0);
        check("reset", "acc", {6'd0, accmodule}, 8'd0);
        check("reset", "state", {6'd0, arb_state}, 8'd0);
        check("reset", "nb_int", {6'd0, nb_interrupts}, 8'd0);
        check("reset", "nb_to", {6'd0, nb_timeouts}, 8'd0);
        reset = 1'b0;

        // Single M2 grant then release to IDLE.
        req = 3'b010;
        step("t1_grant", 3'b010, 2'd1, 2'd0, 2'd0);
        req = 3'b000; done = 3'b010;
        step("t1_release", 3'b000, 2'd0, 2'd0, 2'd0);
        done = 3'b000;
        do_reset("rst_idle");

        // Round-robin M2/M3 back-to-back.
        req = 3'b110;
        step("rr_m2a", 3'b010, 2'd1, 2'd0, 2'd0);
        done = 3'b010;
        step("rr_m3", 3'b100, 2'd1, 2'd0, 2'd0);
        done = 3'b100;
        step("rr_m2b", 3'b010, 2'd1, 2'd0, 2'd0);
        req = 3'b000; done = 3'b010;
        step("rr_idle", 3'b000, 2'd0, 2'd0, 2'd0);
        done = 3'b000;

        // Preemption of M3 after minimum hold.
        req = 3'b100;
        step("pre_m3", 3'b100, 2'd1, 2'd0, 2'd0);
        req = 3'b101;
        step("pre_hold", 3'b100, 2'd1, 2'd0, 2'd0);
        step("pre_drain", 3'b000, 2'd2, 2'd1, 2'd0);
        step("pre_m1", 3'b001, 2'd1, 2'd1, 2'd0);
        req = 3'b100; done = 3'b001;
        step("m1_to_m3", 3'b100, 2'd1, 2'd1, 2'd0);
        done = 3'b000;
        step("m3_h2", 3'b100, 2'd1, 2'd1, 2'd0);
        step("m3_h3", 3'b100, 2'd1, 2'd1, 2'd0);

        // done beats preempt: straight to M1, no DRAIN, no interrupt.
        req = 3'b101; done = 3'b100;
        step("done_vs_pre", 3'b001, 2'd1, 2'd1, 2'd0);
        req = 3'b000; done = 3'b001;
        step("m1_idle", 3'b000, 2'd0, 2'd1, 2'd0);
        done = 3'b000;

        // Interrupt counter saturation (2-bit counter).
        ni_exp = 2'd1;
        for (int i = 0; i < 3; i++) begin
            req = 3'b010;
            step("sat_m2", 3'b010, 2'd1, ni_exp, 2'd0);
            req = 3'b011;
            step("sat_hold", 3'b010, 2'd1, ni_exp, 2'd0);
            ni_exp = (ni_exp == 2'd3) ? 2'd3 : ni_exp + 2'd1;
            step("sat_drain", 3'b000, 2'd2, ni_exp, 2'd0);
            step("sat_m1", 3'b001, 2'd1, ni_exp, 2'd0);
            req = 3'b000; done = 3'b001;
            step("sat_idle", 3'b000, 2'd0, ni_exp, 2'd0);
            done = 3'b000;
        end

        // Long M2 tenure with M3 waiting.
        req = 3'b010;
        step("to_m2", 3'b010, 2'd1, 2'd3, 2'd0);
        req = 3'b110;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            step("to_hold", 3'b010, 2'd1, 2'd3, 2'd0);
        end
        step("to_drain", 3'b000, 2'd2, 2'd3, 2'd1);
        step("to_m3", 3'b100, 2'd1, 2'd3, 2'd1);
`else
        for (int i = 0; i < 12; i++) begin
            step("no_to_hold", 3'b010, 2'd1, 2'd3, 2'd0);
        end
`endif

        // Reset during BUSY.
        do_reset("rst_busy");
        check("post_rst", "nb_int", {6'd0, nb_interrupts}, 8'd0);
        check("post_rst", "nb_to", {6'd0, nb_timeouts}, 8'd0);
        step("post_rst_idle", 3'b000, 2'd0, 2'd0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_share_arbiter.md
Name: mem_share_arbiter

Overview:
- Registered arbiter that shares one memory port between three masters: M1 (urgent), M2 and M3.
- M1 has fixed top priority and may preempt M2 or M3 after a minimum tenure.
- M2 and M3 alternate priority round-robin.
- Drives one-hot grant, encoded owner and saturating statistics counters. Sits between the masters' request/done lines and the memory mux select.

Parameters:
- MIN_HOLD, 2: minimum cycles an M2/M3 owner keeps the grant before M1 may preempt it (≥1).
- MAX_HOLD, 8: cycle limit on any tenure when the timeout feature is compiled in (> MIN_HOLD).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  3  request; bit0=M1, bit1=M2, bit2=M3; level, held until served
- done  in  3  per-master end-of-access; only the current owner's bit is used
- gnt  out  3  one-hot grant, registered; all-zero when no owner
- accmodule  out  2  owner code: 0 none, 1 M1, 2 M2, 3 M3
- arb_state  out  2  FSM state: 0 IDLE, 1 BUSY, 2 DRAIN
- nb_interrupts  out  CNT_W  preemption count, saturating
- nb_timeouts  out  CNT_W  timeout count, saturating; held 0 when feature absent

Behaviour:
- Reset values: gnt=0, accmodule=0, arb_state=IDLE, both counters 0, hold_cnt=0, rr_ptr=M2 (M2 wins the next M2/M3 contention), mask=0.
- Arbitration function pick(req & ~mask):
  - M1 if set.
  - Else if both M2 and M3 are set, rr_ptr decides.
  - Else whichever single one is set.
  - rr_ptr flips to the other of M2/M3 whenever M2 or M3 is granted.
- IDLE: if pick is non-empty, then next cycle state=BUSY, gnt=pick, hold_cnt=1. Request-to-grant latency is 1 cycle. Otherwise stay in IDLE.
- BUSY (owner O); evaluate in this priority order each cycle:
  1. done[O]=1 or req[O]=0: release. If pick(req with O's bit cleared) is non-empty, grant it next cycle (back-to-back, no idle cycle) and reset hold_cnt=1. Otherwise go to IDLE.
  2. O≠M1, req[0]=1, hold_cnt≥MIN_HOLD: preempt. Go to DRAIN, gnt=0, nb_interrupts+1. Next cycle grant M1.
  3. Timeout (feature only), hold_cnt==MAX_HOLD: go to DRAIN, set mask[O]=1, nb_timeouts+1.
  4. Otherwise hold; hold_cnt+1, saturating at MAX_HOLD.
- M1 is never preempted.
- DRAIN: exactly one cycle with gnt=0. Then arbitrate with pick(req & ~mask): go to BUSY if non-empty, else IDLE. Clear mask when the next grant is issued or on IDLE entry.
- Simultaneous events:
  - done with a preempt condition: done wins and no interrupt is counted. M1 still wins the back-to-back pick.
  - done with timeout: done wins.
- done bits of non-owners are ignored. A request dropped while waiting is simply not considered.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-tenure: gnt drops asynchronously; no counter update for the aborted tenure.
- gnt is always zero or one-hot. accmodule is always consistent with gnt in the same cycle.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined: MAX_HOLD timeout, mask and nb_timeouts are active as described above.
- Undefined:
  - An owner holds until done, req drop or preemption.
  - nb_timeouts is tied to 0.
  - mask logic is absent; hold_cnt saturates at MIN_HOLD.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, BUSY, DRAIN)
  - master index constants M1=0, M2=1, M3=2
  - accmodule codes ACC_NONE/ACC_M1/ACC_M2/ACC_M3
- Sub-module mem_arb_sat_cnt (CNT_W, inc, clear, q): saturating counter, instantiated twice.

Test Plan:
- After reset, req=3'b010 → gnt=3'b010 and accmodule=2 one cycle later. done[1] with req=0 → IDLE next cycle, gnt=0.
- req=3'b110 held, done pulsed each tenure → grants alternate M2, M3, M2, with no idle cycle between tenures.
- M3 owns at hold_cnt=1 and req[0] rises → stays M3 one more cycle, then DRAIN (gnt=0) for one cycle, then gnt=3'b001; nb_interrupts=1.
- done[2] and req[0] in the same cycle at hold_cnt=3 → gnt=3'b001 next cycle with no DRAIN; nb_interrupts unchanged.
- MEM_ARB_TIMEOUT_EN defined, M2 holds with no done, req=3'b110 → after 8 BUSY cycles: DRAIN, then gnt=3'b100; nb_timeouts=1. Undefined: M2 keeps the grant indefinitely.
- Force nb_interrupts to all-ones, then preempt → value stays all-ones. Assert reset during BUSY → gnt=0 immediately, arb_state=IDLE.
